// File: rtl/rca_config_pkg.sv
// Shared constants, table layout and FSM encoding for the RCA configuration bank.
package rca_config_pkg;

    localparam int NUM_RCAS        = 3;
    localparam int NUM_READ_PORTS  = 5;
    localparam int NUM_WRITE_PORTS = 2;
    localparam int REG_ADDR_W      = 5;

    typedef struct packed {
        logic [NUM_WRITE_PORTS-1:0][REG_ADDR_W-1:0] dest;
        logic [NUM_READ_PORTS-1:0][REG_ADDR_W-1:0]  src;
    } rca_config_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_COPY = 2'd2
    } rca_state_e;

    // Select widths never collapse to zero bits, even for a single context.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rca_config_context.sv
// One accelerator context: shadow slots with written bits, active slots and active-valid.
// Writes land in shadow one edge after wr_en; copy_en moves shadow to active on its edge.
module rca_config_context
    import rca_config_pkg::*;
#(
    parameter int NUM_READ_PORTS  = rca_config_pkg::NUM_READ_PORTS,
    parameter int NUM_WRITE_PORTS = rca_config_pkg::NUM_WRITE_PORTS,
    parameter int REG_ADDR_W      = rca_config_pkg::REG_ADDR_W,
    parameter int PORT_SEL_W      = 3
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       wr_en,
    input  logic                                       wr_dest,
    input  logic [PORT_SEL_W-1:0]                      wr_port,
    input  logic [REG_ADDR_W-1:0]                      wr_addr,
    input  logic                                       copy_en,
    output logic [NUM_READ_PORTS-1:0][REG_ADDR_W-1:0]  act_src,
    output logic [NUM_WRITE_PORTS-1:0][REG_ADDR_W-1:0] act_dest,
    output logic                                       act_vld
);

    logic [NUM_READ_PORTS-1:0][REG_ADDR_W-1:0]  sh_src_q,   sh_src_d;
    logic [NUM_WRITE_PORTS-1:0][REG_ADDR_W-1:0] sh_dest_q,  sh_dest_d;
    logic [NUM_READ_PORTS-1:0]                  src_wr_q,   src_wr_d;
    logic [NUM_WRITE_PORTS-1:0]                 dest_wr_q,  dest_wr_d;
    logic [NUM_READ_PORTS-1:0][REG_ADDR_W-1:0]  act_src_q,  act_src_d;
    logic [NUM_WRITE_PORTS-1:0][REG_ADDR_W-1:0] act_dest_q, act_dest_d;
    logic                                       act_vld_q,  act_vld_d;

    always_comb begin
        sh_src_d   = sh_src_q;
        sh_dest_d  = sh_dest_q;
        src_wr_d   = src_wr_q;
        dest_wr_d  = dest_wr_q;
        act_src_d  = act_src_q;
        act_dest_d = act_dest_q;
        act_vld_d  = act_vld_q;
        if (wr_en) begin
            if (!wr_dest) begin
                for (int i = 0; i < NUM_READ_PORTS; i++) begin
                    if (wr_port == PORT_SEL_W'(i)) begin
                        sh_src_d[i] = wr_addr;
                        src_wr_d[i] = 1'b1;
                    end
                end
            end else begin
                for (int i = 0; i < NUM_WRITE_PORTS; i++) begin
                    if (wr_port == PORT_SEL_W'(i)) begin
                        sh_dest_d[i] = wr_addr;
                        dest_wr_d[i] = 1'b1;
                    end
                end
            end
        end
        // The copy reads the registered shadow, so a write in the same cycle is not included.
        if (copy_en) begin
            act_src_d  = sh_src_q;
            act_dest_d = sh_dest_q;
            act_vld_d  = (&src_wr_q) & (&dest_wr_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_src_q   <= '0;
            sh_dest_q  <= '0;
            src_wr_q   <= '0;
            dest_wr_q  <= '0;
            act_src_q  <= '0;
            act_dest_q <= '0;
            act_vld_q  <= 1'b0;
        end else begin
            sh_src_q   <= sh_src_d;
            sh_dest_q  <= sh_dest_d;
            src_wr_q   <= src_wr_d;
            dest_wr_q  <= dest_wr_d;
            act_src_q  <= act_src_d;
            act_dest_q <= act_dest_d;
            act_vld_q  <= act_vld_d;
        end
    end

    assign act_src  = act_src_q;
    assign act_dest = act_dest_q;
    assign act_vld  = act_vld_q;

endmodule

// File: rtl/rca_config_bank.sv
// Shadow/active register-address bank for NUM_RCAS accelerator contexts with deferred commit.
// Commit done two cycles after accept at best; reads are registered; cfg_ready low outside IDLE.
module rca_config_bank
    import rca_config_pkg::*;
#(
    parameter int  NUM_RCAS        = rca_config_pkg::NUM_RCAS,
    parameter int  NUM_READ_PORTS  = rca_config_pkg::NUM_READ_PORTS,
    parameter int  NUM_WRITE_PORTS = rca_config_pkg::NUM_WRITE_PORTS,
    parameter int  REG_ADDR_W      = rca_config_pkg::REG_ADDR_W,
    localparam int RCA_SEL_W       = sel_width(NUM_RCAS),
    localparam int PORT_SEL_W      = sel_width((NUM_READ_PORTS > NUM_WRITE_PORTS) ?
                                               NUM_READ_PORTS : NUM_WRITE_PORTS)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  cfg_valid,
    output logic                                  cfg_ready,
    input  logic [RCA_SEL_W-1:0]                  cfg_rca_sel,
    input  logic                                  cfg_src_dest,
    input  logic [PORT_SEL_W-1:0]                 cfg_port_sel,
    input  logic [REG_ADDR_W-1:0]                 cfg_reg_addr,
    input  logic                                  commit_req,
    input  logic [RCA_SEL_W-1:0]                  commit_rca_sel,
    output logic                                  commit_done,
    input  logic                                  commit_flush,
    input  logic [NUM_RCAS-1:0]                   busy_mask,
    input  logic [RCA_SEL_W-1:0]                  rd_rca_sel,
    output logic [NUM_READ_PORTS*REG_ADDR_W-1:0]  rd_src_addrs,
    output logic [NUM_WRITE_PORTS*REG_ADDR_W-1:0] rd_dest_addrs,
    output logic                                  rd_cfg_valid,
    output logic                                  cfg_err
);

    rca_state_e               state_q, state_d;
    logic [RCA_SEL_W-1:0]     sel_q, sel_d;
    logic                     ready_en_q, ready_en_d;
    logic                     cfg_err_q, cfg_err_d;
    logic                     wr_fire, wr_ok, busy_sel, copy_go;

    logic [NUM_RCAS-1:0][NUM_READ_PORTS-1:0][REG_ADDR_W-1:0]  ctx_src;
    logic [NUM_RCAS-1:0][NUM_WRITE_PORTS-1:0][REG_ADDR_W-1:0] ctx_dest;
    logic [NUM_RCAS-1:0]                                      ctx_vld;

    logic [NUM_READ_PORTS-1:0][REG_ADDR_W-1:0]  rd_src_q,  rd_src_d;
    logic [NUM_WRITE_PORTS-1:0][REG_ADDR_W-1:0] rd_dest_q, rd_dest_d;
    logic                                       rd_vld_q,  rd_vld_d;

    assign wr_fire = cfg_valid & cfg_ready;
    assign wr_ok   = wr_fire
                   && (int'(cfg_rca_sel) < NUM_RCAS)
                   && (int'(cfg_port_sel) < (cfg_src_dest ? NUM_WRITE_PORTS : NUM_READ_PORTS));

    always_comb begin
        cfg_err_d = cfg_err_q | (wr_fire & ~wr_ok);
        busy_sel  = 1'b0;
        for (int i = 0; i < NUM_RCAS; i++) begin
            if (sel_q == RCA_SEL_W'(i)) busy_sel = busy_mask[i];
        end
    end

    // ready_en_q keeps cfg_ready low until the first edge after reset release.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        ready_en_d  = 1'b1;
        cfg_ready   = 1'b0;
        commit_done = 1'b0;
        copy_go     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cfg_ready = ready_en_q;
                if (ready_en_q && commit_req) begin
                    sel_d   = commit_rca_sel;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (commit_flush)  state_d = ST_IDLE;
                else if (!busy_sel) state_d = ST_COPY;
            end
            ST_COPY: begin
                // Flush is ignored here; only a re-asserted busy can defer the copy.
                if (!busy_sel) begin
                    copy_go     = 1'b1;
                    commit_done = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            ready_en_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            ready_en_q <= ready_en_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    for (genvar g = 0; g < NUM_RCAS; g++) begin : g_ctx
        rca_config_context #(
            .NUM_READ_PORTS  (NUM_READ_PORTS),
            .NUM_WRITE_PORTS (NUM_WRITE_PORTS),
            .REG_ADDR_W      (REG_ADDR_W),
            .PORT_SEL_W      (PORT_SEL_W)
        ) u_ctx (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (wr_ok && (cfg_rca_sel == RCA_SEL_W'(g))),
            .wr_dest  (cfg_src_dest),
            .wr_port  (cfg_port_sel),
            .wr_addr  (cfg_reg_addr),
            .copy_en  (copy_go && (sel_q == RCA_SEL_W'(g))),
            .act_src  (ctx_src[g]),
            .act_dest (ctx_dest[g]),
            .act_vld  (ctx_vld[g])
        );
    end

    always_comb begin
        rd_src_d  = '0;
        rd_dest_d = '0;
        rd_vld_d  = 1'b0;
        for (int i = 0; i < NUM_RCAS; i++) begin
            if (rd_rca_sel == RCA_SEL_W'(i)) begin
                rd_src_d  = ctx_src[i];
                rd_dest_d = ctx_dest[i];
                rd_vld_d  = ctx_vld[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_src_q  <= '0;
            rd_dest_q <= '0;
            rd_vld_q  <= 1'b0;
        end else begin
            rd_src_q  <= rd_src_d;
            rd_dest_q <= rd_dest_d;
            rd_vld_q  <= rd_vld_d;
        end
    end

    assign rd_src_addrs  = rd_src_q;
    assign rd_dest_addrs = rd_dest_q;
    assign rd_cfg_valid  = rd_vld_q;
    assign cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_rca_config_bank.sv
// Directed bench for rca_config_bank: per-cycle check against a slot-table model plus literal pins.
module tb_rca_config_bank;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_rca_sel = '0;
    logic        cfg_src_dest = 1'b0;
    logic [2:0]  cfg_port_sel = '0;
    logic [4:0]  cfg_reg_addr = '0;
    logic        commit_req = 1'b0;
    logic [1:0]  commit_rca_sel = '0;
    logic        commit_done;
    logic        commit_flush = 1'b0;
    logic [2:0]  busy_mask = '0;
    logic [1:0]  rd_rca_sel = '0;
    logic [24:0] rd_src_addrs;
    logic [9:0]  rd_dest_addrs;
    logic        rd_cfg_valid;
    logic        cfg_err;

    int n_cmp = 0;
    int n_bad = 0;

    rca_config_bank dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_rca_sel    (cfg_rca_sel),
        .cfg_src_dest   (cfg_src_dest),
        .cfg_port_sel   (cfg_port_sel),
        .cfg_reg_addr   (cfg_reg_addr),
        .commit_req     (commit_req),
        .commit_rca_sel (commit_rca_sel),
        .commit_done    (commit_done),
        .commit_flush   (commit_flush),
        .busy_mask      (busy_mask),
        .rd_rca_sel     (rd_rca_sel),
        .rd_src_addrs   (rd_src_addrs),
        .rd_dest_addrs  (rd_dest_addrs),
        .rd_cfg_valid   (rd_cfg_valid),
        .cfg_err        (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    // Model: slots 0..4 are sources, 5..6 destinations. phase 0 idle, 1 waiting, 2 copying.
    int m_sh [3][7];
    bit m_wb [3][7];
    int m_act[3][7];
    bit m_av [3];
    int m_rd [7];
    bit m_rdv, m_err, m_started;
    int m_phase, m_psel;

    task automatic model_clear();
        for (int c = 0; c < 3; c++) begin
            for (int s = 0; s < 7; s++) begin
                m_sh[c][s] = 0; m_wb[c][s] = 0; m_act[c][s] = 0;
            end
            m_av[c] = 0;
        end
        for (int s = 0; s < 7; s++) m_rd[s] = 0;
        m_rdv = 0; m_err = 0; m_started = 0; m_phase = 0; m_psel = 0;
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_clear();
            end else begin
                bit rdy, all;
                int lim, nph;
                rdy = m_started && (m_phase == 0);
                for (int s = 0; s < 7; s++)
                    m_rd[s] = (rd_rca_sel < 3) ? m_act[rd_rca_sel][s] : 0;
                m_rdv = (rd_rca_sel < 3) ? m_av[rd_rca_sel] : 0;
                if (rdy && cfg_valid) begin
                    lim = cfg_src_dest ? 2 : 5;
                    if (cfg_rca_sel < 3 && cfg_port_sel < lim) begin
                        m_sh[cfg_rca_sel][cfg_src_dest ? 5 + cfg_port_sel : cfg_port_sel] = cfg_reg_addr;
                        m_wb[cfg_rca_sel][cfg_src_dest ? 5 + cfg_port_sel : cfg_port_sel] = 1;
                    end else begin
                        m_err = 1;
                    end
                end
                nph = m_phase;
                if (m_phase == 0) begin
                    if (rdy && commit_req) begin nph = 1; m_psel = commit_rca_sel; end
                end else if (m_phase == 1) begin
                    if (commit_flush) nph = 0;
                    else if (!busy_mask[m_psel]) nph = 2;
                end else if (!busy_mask[m_psel]) begin
                    all = 1;
                    for (int s = 0; s < 7; s++) begin
                        m_act[m_psel][s] = m_sh[m_psel][s];
                        all = all & m_wb[m_psel][s];
                    end
                    m_av[m_psel] = all;
                    nph = 0;
                end
                m_phase = nph;
                m_started = 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [24:0] e_src;
        logic [9:0]  e_dest;
        for (int s = 0; s < 5; s++) e_src[s*5 +: 5] = m_rd[s][4:0];
        for (int s = 0; s < 2; s++) e_dest[s*5 +: 5] = m_rd[5+s][4:0];
        cmp("cfg_ready",    32'(cfg_ready),     32'(m_started && m_phase == 0));
        cmp("commit_done",  32'(commit_done),   32'(m_phase == 2 && !busy_mask[m_psel]));
        cmp("cfg_err",      32'(cfg_err),       32'(m_err));
        cmp("rd_src",       32'(rd_src_addrs),  32'(e_src));
        cmp("rd_dest",      32'(rd_dest_addrs), 32'(e_dest));
        cmp("rd_cfg_valid", 32'(rd_cfg_valid),  32'(m_rdv));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_at_neg(input string name, input logic [31:0] got_dummy);
        got_dummy = got_dummy;
    endtask

    task automatic do_write(input int c, input bit d, input int p, input int a);
        cfg_valid = 1'b1; cfg_rca_sel = 2'(c); cfg_src_dest = d;
        cfg_port_sel = 3'(p); cfg_reg_addr = 5'(a);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic do_commit(input int c);
        commit_req = 1'b1; commit_rca_sel = 2'(c);
        tick();
        commit_req = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        cmp("reset_ready", 32'(cfg_ready), 32'd0);
        cmp("reset_rd_src", 32'(rd_src_addrs), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        cmp("ready_before_first_edge", 32'(cfg_ready), 32'd0);
        tick();
        @(negedge clk);
        cmp("ready_after_release", 32'(cfg_ready), 32'd1);

        // Full context 1; last slot rides with the commit request (cycle N).
        tick();
        rd_rca_sel = 2'd1;
        do_write(1, 0, 0, 3);  do_write(1, 0, 1, 7);  do_write(1, 0, 2, 11);
        do_write(1, 0, 3, 19); do_write(1, 0, 4, 23); do_write(1, 1, 0, 29);
        cfg_valid = 1'b1; cfg_rca_sel = 2'd1; cfg_src_dest = 1'b1; cfg_port_sel = 3'd1;
        cfg_reg_addr = 5'd31; commit_req = 1'b1; commit_rca_sel = 2'd1;
        tick();
        cfg_valid = 1'b0; commit_req = 1'b0;
        @(negedge clk);
        cmp("n1_ready_low", 32'(cfg_ready), 32'd0);
        cmp("n1_no_done", 32'(commit_done), 32'd0);
        tick(); @(negedge clk);
        cmp("n2_done", 32'(commit_done), 32'd1);
        tick(); @(negedge clk);
        cmp("n3_old_valid", 32'(rd_cfg_valid), 32'd0);
        tick(); @(negedge clk);
        cmp("n4_src", 32'(rd_src_addrs), 32'({5'd23, 5'd19, 5'd11, 5'd7, 5'd3}));
        cmp("n4_dest", 32'(rd_dest_addrs), 32'({5'd31, 5'd29}));
        cmp("n4_valid", 32'(rd_cfg_valid), 32'd1);

        // Partial context 0.
        tick();
        rd_rca_sel = 2'd0;
        do_write(0, 0, 0, 9);
        do_commit(0);
        repeat (4) tick();
        @(negedge clk);
        cmp("partial_src", 32'(rd_src_addrs), 32'd9);
        cmp("partial_valid", 32'(rd_cfg_valid), 32'd0);

        // Context 2 held off by busy for ten cycles.
        tick();
        rd_rca_sel = 2'd2;
        do_write(2, 0, 0, 17);
        busy_mask = 3'b100;
        do_commit(2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cmp("busy_ready_low", 32'(cfg_ready), 32'd0);
            cmp("busy_no_done", 32'(commit_done), 32'd0);
            tick();
        end
        busy_mask = 3'b000;
        @(negedge clk);
        cmp("busy_drop_no_done_yet", 32'(commit_done), 32'd0);
        tick(); @(negedge clk);
        cmp("busy_drop_done", 32'(commit_done), 32'd1);
        repeat (2) tick();
        @(negedge clk);
        cmp("busy_ctx2_src", 32'(rd_src_addrs), 32'd17);

        // Flush while waiting: active context 0 stays {src0=9}.
        tick();
        rd_rca_sel = 2'd0;
        do_write(0, 0, 1, 13);
        busy_mask = 3'b001;
        do_commit(0);
        commit_flush = 1'b1;
        tick();
        commit_flush = 1'b0; busy_mask = 3'b000;
        @(negedge clk);
        cmp("flush_back_idle", 32'(cfg_ready), 32'd1);
        repeat (3) tick();
        @(negedge clk);
        cmp("flush_active_kept", 32'(rd_src_addrs), 32'd9);

        // Flush during the copy cycle is ignored.
        tick();
        do_commit(0);
        tick();
        commit_flush = 1'b1;
        @(negedge clk);
        cmp("flush_in_copy_done", 32'(commit_done), 32'd1);
        tick();
        commit_flush = 1'b0;
        tick(); @(negedge clk);
        cmp("flush_in_copy_src", 32'(rd_src_addrs), 32'd425);

        // Out-of-range writes are dropped and flagged.
        tick();
        rd_rca_sel = 2'd1;
        do_write(1, 1, 2, 1);
        @(negedge clk);
        cmp("err_dest_port", 32'(cfg_err), 32'd1);
        tick();
        do_write(3, 0, 0, 2);
        do_write(0, 0, 5, 4);
        do_commit(1);
        repeat (4) tick();
        @(negedge clk);
        cmp("err_ctx1_src_kept", 32'(rd_src_addrs), 32'({5'd23, 5'd19, 5'd11, 5'd7, 5'd3}));
        cmp("err_ctx1_dest_kept", 32'(rd_dest_addrs), 32'({5'd31, 5'd29}));
        cmp("err_sticky", 32'(cfg_err), 32'd1);

        // Reset while waiting abandons the commit.
        tick();
        rd_rca_sel = 2'd2;
        do_write(2, 0, 1, 21);
        busy_mask = 3'b100;
        do_commit(2);
        #2 rst_n = 1'b0;
        #1;
        cmp("rst_ready_low", 32'(cfg_ready), 32'd0);
        cmp("rst_rd_src", 32'(rd_src_addrs), 32'd0);
        cmp("rst_err_clr", 32'(cfg_err), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1; busy_mask = 3'b000;
        @(negedge clk);
        cmp("rst_ready_pre_edge", 32'(cfg_ready), 32'd0);
        tick(); @(negedge clk);
        cmp("rst_ready_post_edge", 32'(cfg_ready), 32'd1);
        cmp("rst_no_done", 32'(commit_done), 32'd0);
        repeat (4) tick();
        @(negedge clk);
        cmp("rst_rd_src_zero", 32'(rd_src_addrs), 32'd0);
        cmp("rst_rd_valid_zero", 32'(rd_cfg_valid), 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rca_config_bank.md
RCA_CONFIG_BANK -- requirements
Module: rca_config_bank

Interface
- Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter NUM_RCAS, default 3, the number of accelerator contexts.
REQ-002 The block SHALL have parameter NUM_READ_PORTS, default 5, the source-address slots per context.
REQ-003 The block SHALL have parameter NUM_WRITE_PORTS, default 2, the destination-address slots per context.
REQ-004 The block SHALL have parameter REG_ADDR_W, default 5, the register address width.
- Ports (name, direction, width, meaning); one clock; reset is asynchronous and active-low:
REQ-005 clk  in  1  clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 cfg_valid/cfg_ready  in/out  1/1  configuration write handshake.
REQ-008 cfg_rca_sel  in  clog2(NUM_RCAS)  target context.
REQ-009 cfg_src_dest  in  1  0=source slot, 1=destination slot.
REQ-010 cfg_port_sel  in  clog2(max(NUM_READ_PORTS,NUM_WRITE_PORTS))  slot index.
REQ-011 cfg_reg_addr  in  REG_ADDR_W  register address to store.
REQ-012 commit_req  in  1  request to copy shadow config to active.
REQ-013 commit_rca_sel  in  clog2(NUM_RCAS)  context to commit.
REQ-014 commit_done  out  1  one-cycle pulse when the copy occurs.
REQ-015 commit_flush  in  1  abandon a pending commit.
REQ-016 busy_mask  in  NUM_RCAS  per-context "accelerator executing" flags.
REQ-017 rd_rca_sel  in  clog2(NUM_RCAS)  read-port context select.
REQ-018 rd_src_addrs/rd_dest_addrs  out  NUM_READ_PORTS*REG_ADDR_W / NUM_WRITE_PORTS*REG_ADDR_W  active slot addresses.
REQ-019 rd_cfg_valid  out  1  the selected context has every slot written and committed.
REQ-020 cfg_err  out  1  sticky out-of-range write flag.

Function
REQ-021 The block SHALL hold a shadow table and an active table per context, plus a per-slot written bit attached to the shadow table.
REQ-022 A write SHALL fire on cfg_valid&cfg_ready, updating the shadow slot and setting its written bit at the clock edge.
REQ-023 A write with cfg_port_sel >= the slot count for the chosen direction, or cfg_rca_sel >= NUM_RCAS, SHALL be dropped, with cfg_err set until reset.
REQ-024 The FSM SHALL have three states: IDLE, WAIT, COPY.
- IDLE: cfg_ready=1. commit_req latches commit_rca_sel and moves to WAIT.
- WAIT: cfg_ready=0. If commit_flush=1, go to IDLE. Else if busy_mask[sel]=0, go to COPY. Else stay.
- COPY: cfg_ready=0. Copy the whole shadow context to active, record the active-valid bit as the AND of the context's written bits, pulse commit_done, and go to IDLE.
REQ-025 A write and a commit_req in the same IDLE cycle SHALL both be accepted, and the write SHALL be included in that commit.
REQ-026 commit_flush in COPY SHALL be ignored; the copy completes.
REQ-027 commit_req outside IDLE SHALL be ignored; the requester holds it until accepted.
REQ-028 The minimum commit latency SHALL be:
- accept at cycle N;
- commit_done during N+2;
- new active data at the rd outputs for a matching rd_rca_sel during N+4.
REQ-029 The rd outputs SHALL be registered with 1-cycle latency from rd_rca_sel and from active-table updates.
REQ-030 The active table of a context SHALL NOT change while its busy_mask bit is 1.

Reset
REQ-031 On rst_n=0, asynchronously: FSM=IDLE; all shadow/active slots, written bits and active-valid bits =0; commit_done=0; cfg_err=0; rd_* outputs =0; cfg_ready=0 while rst_n=0, and =1 from the first clock after release.
REQ-032 A reset during WAIT or COPY SHALL abandon the commit with no partial copy visible after release.

Structure
REQ-033 rca_config_t (parametrised by port counts), the FSM state enum, and the NUM_RCAS/NUM_READ_PORTS/NUM_WRITE_PORTS constants SHALL live in the shared rca_config package.
REQ-034 One sub-module, rca_config_context, SHALL hold one context's shadow/active storage, written bits and active-valid bit; it SHALL be instantiated NUM_RCAS times.

Verification
REQ-035 Write all 5 src and 2 dest slots of ctx 1 (src0=5'd3 ... dest1=5'd31) -> commit with busy_mask=0 -> commit_done at N+2; rd_rca_sel=1 shows the values and rd_cfg_valid=1 at N+4.
REQ-036 Write only src0 of ctx 0 -> commit -> copied, rd_cfg_valid=0.
REQ-037 busy_mask[2]=1 for 10 cycles during a ctx 2 commit -> stays in WAIT with cfg_ready=0 and no commit_done; busy drops -> commit_done 2 cycles later.
REQ-038 commit_flush in WAIT -> back to IDLE, active unchanged, no commit_done; flush asserted in COPY -> ignored.
REQ-039 cfg_src_dest=1 with cfg_port_sel=2 (NUM_WRITE_PORTS=2) -> no table change, cfg_err=1 until reset.
REQ-040 rst_n asserted in WAIT -> after release cfg_ready=1, all rd outputs 0, no commit_done.
